// File: rtl/ucaspian_cmd_pkg.sv
// Shared command definitions for the uCaspian SPI command path.
// Exports: deframer_state_t, OP_* opcodes, op_known(), op_len().
package ucaspian_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_EMIT    = 2'd2
  } deframer_state_t;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_RUN      = 8'h02;
  localparam logic [7:0] OP_SET_ADDR = 8'h03;
  localparam logic [7:0] OP_SET_DATA = 8'h04;
  localparam logic [7:0] OP_READ_CFG = 8'h05;
  localparam logic [7:0] OP_SPIKE    = 8'h06;

  function automatic logic op_known(input logic [7:0] op);
    logic k;
    case (op)
      OP_NOP, OP_CLEAR, OP_RUN, OP_SET_ADDR,
      OP_SET_DATA, OP_READ_CFG, OP_SPIKE: k = 1'b1;
      default:                            k = 1'b0;
    endcase
    return k;
  endfunction

  function automatic logic [2:0] op_len(input logic [7:0] op);
    logic [2:0] l;
    case (op)
      OP_READ_CFG:             l = 3'd1;
      OP_RUN, OP_SET_ADDR:     l = 3'd2;
      OP_SPIKE:                l = 3'd3;
      OP_SET_DATA:             l = 3'd4;
      default:                 l = 3'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/cmd_deframer.sv
// Splits an SPI byte stream into opcode + MSB-first payload commands.
// Ports: clk, reset, flush; in_data/in_vld/in_rdy byte input;
//   cmd_op/cmd_payload/cmd_len/cmd_vld/cmd_rdy command output;
//   err_unknown pulse and saturating err_count for bad opcodes.
import ucaspian_cmd_pkg::*;

module cmd_deframer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [7:0]  cmd_op,
  output logic [31:0] cmd_payload,
  output logic [2:0]  cmd_len,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic        err_unknown,
  output logic [7:0]  err_count
);

  deframer_state_t state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] payload_q, payload_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_unknown_q, err_unknown_d;
  logic [7:0]  err_count_q, err_count_d;

  logic in_acc;
  logic cmd_acc;
  logic [2:0] cnt_inc;

  // Both handshake outputs come straight from the state register.
  assign in_rdy      = (state_q != ST_EMIT);
  assign cmd_vld     = (state_q == ST_EMIT);
  assign cmd_op      = op_q;
  assign cmd_payload = payload_q;
  assign cmd_len     = len_q;
  assign err_unknown = err_unknown_q;
  assign err_count   = err_count_q;

  assign in_acc  = in_vld & in_rdy;
  assign cmd_acc = cmd_vld & cmd_rdy;
  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    payload_d     = payload_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_unknown_d = 1'b0;
    err_count_d   = err_count_q;
    if (flush) begin
      // Flush wins: any byte or command handshake this cycle is dropped.
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_acc) begin
            if (op_known(in_data)) begin
              op_d      = in_data;
              len_d     = op_len(in_data);
              payload_d = 32'd0;
              cnt_d     = 3'd0;
              state_d   = (op_len(in_data) == 3'd0)
                        ? ST_EMIT : ST_PAYLOAD;
            end else begin
              err_unknown_d = 1'b1;
              if (err_count_q != 8'hFF)
                err_count_d = err_count_q + 8'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (in_acc) begin
            payload_d = {payload_q[23:0], in_data};
            cnt_d     = cnt_inc;
            if (cnt_inc == len_q)
              state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (cmd_acc)
            state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= 8'd0;
      payload_q     <= 32'd0;
      len_q         <= 3'd0;
      cnt_q         <= 3'd0;
      err_unknown_q <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      payload_q     <= payload_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      err_unknown_q <= err_unknown_d;
      err_count_q   <= err_count_d;
    end
  end

endmodule

// File: tb/tb_cmd_deframer.sv
// Self-checking bench for cmd_deframer: directed frames plus a
// randomized stream compared cycle-by-cycle with a frame-parser model.
module tb_cmd_deframer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_payload;
  logic [2:0]  cmd_len;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        err_unknown;
  logic [7:0]  err_count;

  cmd_deframer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .cmd_op(cmd_op), .cmd_payload(cmd_payload), .cmd_len(cmd_len),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .err_unknown(err_unknown), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Opcode table; 7 marks an unknown opcode.
  function automatic int tb_len(input logic [7:0] b);
    case (b)
      8'h00, 8'h01: return 0;
      8'h05:        return 1;
      8'h02, 8'h03: return 2;
      8'h06:        return 3;
      8'h04:        return 4;
      default:      return 7;
    endcase
  endfunction

  // Behavioural model: a frame parser holding at most one pending command.
  bit          m_pend, m_inframe, m_err;
  int          m_need, m_got, m_cnt;
  logic [7:0]  m_op;
  logic [31:0] m_pay;
  int          delivered;
  logic [7:0]  last_op;
  logic [31:0] last_pay;

  initial begin
    delivered = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pend = 0; m_inframe = 0; m_err = 0;
        m_need = 0; m_got = 0; m_cnt = 0;
        m_op = 0; m_pay = 0;
      end else begin
        m_err = 0;
        if (flush) begin
          m_pend = 0;
          m_inframe = 0;
        end else if (m_pend) begin
          if (cmd_rdy) begin
            m_pend = 0;
            delivered++;
            last_op = m_op;
            last_pay = m_pay;
          end
        end else if (in_vld) begin
          if (!m_inframe) begin
            if (tb_len(in_data) == 7) begin
              m_err = 1;
              if (m_cnt < 255) m_cnt++;
            end else begin
              m_op = in_data;
              m_need = tb_len(in_data);
              m_pay = 0;
              m_got = 0;
              if (m_need == 0) m_pend = 1;
              else m_inframe = 1;
            end
          end else begin
            m_pay = (m_pay << 8) | {24'd0, in_data};
            m_got++;
            if (m_got == m_need) begin
              m_inframe = 0;
              m_pend = 1;
            end
          end
        end
      end
    end
  end

  // Single compare process against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_rdy", {31'd0, in_rdy}, {31'd0, !m_pend});
      chk("cmd_vld", {31'd0, cmd_vld}, {31'd0, m_pend});
      chk("err_unknown", {31'd0, err_unknown}, {31'd0, m_err});
      chk("err_count", {24'd0, err_count}, m_cnt);
      if (m_pend) begin
        chk("cmd_op", {24'd0, cmd_op}, {24'd0, m_op});
        chk("cmd_payload", cmd_payload, m_pay);
        chk("cmd_len", {29'd0, cmd_len}, m_need);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_vld = 1'b1;
    in_data = b;
    tick();
    in_vld = 1'b0;
  endtask

  logic [7:0] known_ops [7];
  int d0;

  initial begin
    known_ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    reset = 1'b1; flush = 1'b0; in_vld = 1'b0;
    in_data = 8'h00; cmd_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_payload", cmd_payload, 32'd0);
    chk("rst_op_len", {21'd0, cmd_op, cmd_len}, 32'd0);
    tick();

    // Full 4-byte frame, consumer always ready.
    cmd_rdy = 1'b1;
    send(8'h04); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("d37_vld", {31'd0, cmd_vld}, 32'd1);
    chk("d37_op", {24'd0, cmd_op}, 32'h04);
    chk("d37_pay", cmd_payload, 32'hDEADBEEF);
    chk("d37_len", {29'd0, cmd_len}, 32'd4);
    chk("d37_model_pay", m_pay, 32'hDEADBEEF);
    tick();
    chk("d37_vld_done", {31'd0, cmd_vld}, 32'd0);

    // Back-pressure: outputs held, no bytes taken.
    cmd_rdy = 1'b0;
    send(8'h02); send(8'h12); send(8'h34);
    for (int i = 0; i < 5; i++) begin
      chk("d38_vld", {31'd0, cmd_vld}, 32'd1);
      chk("d38_in_rdy", {31'd0, in_rdy}, 32'd0);
      chk("d38_pay", cmd_payload, 32'h00001234);
      chk("d38_len", {29'd0, cmd_len}, 32'd2);
      in_vld = 1'b1; in_data = 8'h55;
      tick();
    end
    in_vld = 1'b0;
    cmd_rdy = 1'b1;
    tick();
    chk("d38_released", {31'd0, cmd_vld}, 32'd0);

    // Unknown opcode then zero-length command.
    send(8'h7F);
    chk("d39_err_pulse", {31'd0, err_unknown}, 32'd1);
    chk("d39_err_count", {24'd0, err_count}, 32'd1);
    send(8'h01);
    chk("d39_err_clear", {31'd0, err_unknown}, 32'd0);
    chk("d39_vld", {31'd0, cmd_vld}, 32'd1);
    chk("d39_op", {24'd0, cmd_op}, 32'h01);
    chk("d39_len", {29'd0, cmd_len}, 32'd0);
    chk("d39_pay", cmd_payload, 32'd0);
    tick();

    // Saturation.
    for (int i = 0; i < 300; i++) send(8'h7F);
    tick();
    chk("d40_sat", {24'd0, err_count}, 32'd255);

    // Flush mid-frame.
    d0 = delivered;
    send(8'h04); send(8'h11); send(8'h22);
    flush = 1'b1; tick(); flush = 1'b0;
    send(8'h03); send(8'hAA); send(8'hBB);
    tick(); tick();
    chk("d41_count", delivered - d0, 32'd1);
    chk("d41_op", {24'd0, last_op}, 32'h03);
    chk("d41_pay", last_pay, 32'h0000AABB);
    chk("d41_errcnt", {24'd0, err_count}, 32'd255);

    // Asynchronous reset mid-payload.
    send(8'h04); send(8'h11);
    in_vld = 1'b1; in_data = 8'h22;
    #2 reset = 1'b1;
    #1;
    chk("d42_vld", {31'd0, cmd_vld}, 32'd0);
    chk("d42_errcnt", {24'd0, err_count}, 32'd0);
    chk("d42_pay", cmd_payload, 32'd0);
    in_vld = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    send(8'h06); send(8'h01); send(8'h02); send(8'h03);
    chk("d42_next_vld", {31'd0, cmd_vld}, 32'd1);
    chk("d42_next_pay", cmd_payload, 32'h00010203);
    chk("d42_next_len", {29'd0, cmd_len}, 32'd3);
    tick();

    // Randomized stream.
    for (int i = 0; i < 4000; i++) begin
      in_vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 3)
        in_data = 8'($urandom_range(0, 255));
      else
        in_data = known_ops[$urandom_range(0, 6)];
      cmd_rdy = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 47) == 0);
      tick();
    end
    in_vld = 1'b0; flush = 1'b0; cmd_rdy = 1'b1;
    tick(); tick();
    chk("rand_delivered_some", {31'd0, delivered > d0 + 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
